// File: rtl/logic_arbiter16_if.sv
// Bundle of requester and result-consumer signals for logic_arbiter16.
// The arbiter connects through the slave modport, and the requester/consumer side connects through master.
interface logic_arbiter16_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    i_reqValid;
  logic [2*N_REQ-1:0]  i_reqOp;
  logic [16*N_REQ-1:0] i_reqX;
  logic [16*N_REQ-1:0] i_reqY;
  logic                i_resReady;
  logic [N_REQ-1:0]    o_grant;
  logic                o_resValid;
  logic [15:0]         o_resOut;
  logic [IDW-1:0]      o_resId;
  logic [15:0]         o_opCnt;

  modport master (
    output i_reqValid, i_reqOp, i_reqX, i_reqY, i_resReady,
    input  o_grant, o_resValid, o_resOut, o_resId, o_opCnt
  );

  modport slave (
    input  i_reqValid, i_reqOp, i_reqX, i_reqY, i_resReady,
    output o_grant, o_resValid, o_resOut, o_resId, o_opCnt
  );
endinterface

// File: rtl/logic_arbiter16.sv
// Round-robin arbiter in front of a shared 16-bit bitwise logic unit.
// The result register has a one-entry valid/ready output. A new operation is
// accepted whenever the register is empty or is being drained in the same cycle.
module logic_arbiter16 #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  logic_arbiter16_if.slave bus
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_resId;
  logic [15:0]    r_resOut;
  logic [15:0]    r_opCnt;

  logic [IDW-1:0] w_winner;
  logic [IDW:0]   w_sum;
  logic           w_found;
  logic           w_accept;
  logic [N_REQ-1:0] w_grant;
  logic [1:0]     w_op;
  logic [15:0]    w_x;
  logic [15:0]    w_y;
  logic [15:0]    w_result;
  logic [IDW-1:0] w_ptrNext;

  // Find the first active request starting at r_ptr and wrapping modulo N_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(N_REQ)) w_sum = w_sum - (IDW+1)'(N_REQ);
      if (!w_found && bus.i_reqValid[w_sum[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[IDW-1:0];
      end
    end
  end

  assign w_accept = !i_rst && w_found && (r_state == S_EMPTY || bus.i_resReady);

  // Select the winner's opcode and operands, and form the one-hot grant.
  always_comb begin
    w_op    = '0;
    w_x     = '0;
    w_y     = '0;
    w_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_op       = bus.i_reqOp[2*i +: 2];
        w_x        = bus.i_reqX[16*i +: 16];
        w_y        = bus.i_reqY[16*i +: 16];
        w_grant[i] = w_accept;
      end
    end
  end

  // Evaluate the bitwise operation across all 16 bits in parallel.
  always_comb begin
    w_result = '0;
    case (w_op)
      2'b00:   w_result = ~w_x;
      2'b01:   w_result = w_x & w_y;
      2'b10:   w_result = w_x | w_y;
      default: w_result = w_x ^ w_y;
    endcase
  end

  assign w_ptrNext = (w_winner == IDW'(N_REQ-1)) ? '0 : w_winner + 1'b1;

  // Result-register occupancy. A drain in the same cycle as an accept keeps the register full.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_nextState = S_FULL;
      S_FULL:  if (w_accept) w_nextState = S_FULL;
               else if (bus.i_resReady) w_nextState = S_EMPTY;
      default: w_nextState = S_EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_EMPTY;
    else       r_state <= w_nextState;
  end

  // Load the result, requester id, pointer and counter on every accepted operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr    <= '0;
      r_resId  <= '0;
      r_resOut <= '0;
      r_opCnt  <= '0;
    end else if (w_accept) begin
      r_ptr    <= w_ptrNext;
      r_resId  <= w_winner;
      r_resOut <= w_result;
      r_opCnt  <= r_opCnt + 16'd1;
    end
  end

  assign bus.o_grant    = w_grant;
  assign bus.o_resValid = (r_state == S_FULL);
  assign bus.o_resOut   = r_resOut;
  assign bus.o_resId    = r_resId;
  assign bus.o_opCnt    = r_opCnt;

endmodule

// File: tb/tb_logic_arbiter16.sv
// Randomized and directed bench for logic_arbiter16, checked against a
// behavioural model of the arbitration rules and the result register.
module tb_logic_arbiter16;
  localparam int N = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_arbiter16_if #(.N_REQ(N), .IDW(IDW)) bus ();

  logic_arbiter16 #(.N_REQ(N), .IDW(IDW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad = 0;

  // Behavioural model state
  int          mPtr = 0;
  bit          mFull = 1'b0;
  logic [15:0] mOut = '0;
  int          mId = 0;
  logic [15:0] mCnt = '0;
  logic [N-1:0] lastGrant;

  // Count one comparison and report it if it differs
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Winning requester index this cycle, or -1 when nothing is accepted
  function automatic int modelWinner();
    int idx;
    if (rst) return -1;
    if (mFull && !bus.i_resReady) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (mPtr + k) % N;
      if (bus.i_reqValid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [2*N-1:0] op,
                               input logic [16*N-1:0] x, input logic [16*N-1:0] y, input logic ready);
    rst = r;
    bus.i_reqValid = v;
    bus.i_reqOp = op;
    bus.i_reqX = x;
    bus.i_reqY = y;
    bus.i_resReady = ready;
  endtask

  // Starts just after a falling edge with inputs applied, and ends at the next falling edge.
  task automatic stepCycle(input string tag);
    int w;
    logic [N-1:0] eg;
    logic [15:0] xs, ys;
    logic [1:0] os;
    #1;
    w = modelWinner();
    eg = (w < 0) ? '0 : (N'(1) << w);
    lastGrant = bus.o_grant;
    checkOutput({tag, ".grant"}, 32'(bus.o_grant), 32'(eg));
    @(posedge clk);
    if (rst) begin
      mPtr = 0; mFull = 0; mOut = '0; mId = 0; mCnt = '0;
    end else if (w >= 0) begin
      xs = bus.i_reqX[16*w +: 16];
      ys = bus.i_reqY[16*w +: 16];
      os = bus.i_reqOp[2*w +: 2];
      case (os)
        2'd0: mOut = ~xs;
        2'd1: mOut = xs & ys;
        2'd2: mOut = xs | ys;
        default: mOut = xs ^ ys;
      endcase
      mId = w;
      mCnt = mCnt + 16'd1;
      mPtr = (w + 1) % N;
      mFull = 1'b1;
    end else if (mFull && bus.i_resReady) begin
      mFull = 1'b0;
    end
    @(negedge clk);
    checkOutput({tag, ".valid"}, 32'(bus.o_resValid), 32'(mFull));
    checkOutput({tag, ".out"}, 32'(bus.o_resOut), 32'(mOut));
    checkOutput({tag, ".id"}, 32'(bus.o_resId), 32'(mId));
    checkOutput({tag, ".cnt"}, 32'(bus.o_opCnt), 32'(mCnt));
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0);
    stepCycle("rst");
    stepCycle("rst");
  endtask

  logic [2*N-1:0]  rOp;
  logic [16*N-1:0] rX, rY;

  initial begin
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    doReset();
    checkOutput("reset.valid", 32'(bus.o_resValid), 32'd0);
    checkOutput("reset.cnt", 32'(bus.o_opCnt), 32'd0);

    // Single NOT from requester 0
    applyStimulus(1'b0, 4'b0001, 8'h00, 64'h00FF, 64'h0, 1'b1);
    stepCycle("not");
    checkOutput("not.grant0", 32'(lastGrant), 32'h1);
    checkOutput("not.out", 32'(bus.o_resOut), 32'hFF00);
    checkOutput("not.id", 32'(bus.o_resId), 32'd0);
    checkOutput("not.cnt", 32'(bus.o_opCnt), 32'd1);
    checkOutput("not.valid", 32'(bus.o_resValid), 32'd1);

    // Opcode sweep on requester 2
    applyStimulus(1'b0, 4'b0100, 8'b00_01_00_00, 64'h0000_F0F0_0000_0000, 64'h0000_FF00_0000_0000, 1'b1);
    stepCycle("and");
    checkOutput("sweep.and", 32'(bus.o_resOut), 32'hF000);
    checkOutput("sweep.id0", 32'(bus.o_resId), 32'd2);
    bus.i_reqOp = 8'b00_10_00_00;
    stepCycle("or");
    checkOutput("sweep.or", 32'(bus.o_resOut), 32'hFFF0);
    checkOutput("sweep.id1", 32'(bus.o_resId), 32'd2);
    bus.i_reqOp = 8'b00_11_00_00;
    stepCycle("xor");
    checkOutput("sweep.xor", 32'(bus.o_resOut), 32'h0FF0);
    checkOutput("sweep.id2", 32'(bus.o_resId), 32'd2);

    // Round-robin fairness with all requesters active
    doReset();
    applyStimulus(1'b0, 4'b1111, 8'h00, {4{16'h1111}}, {4{16'h2222}}, 1'b1);
    for (int i = 0; i < 8; i++) begin
      stepCycle("rr");
      checkOutput("rr.seq", 32'(lastGrant), 32'(1 << (i % 4)));
    end
    checkOutput("rr.cnt8", 32'(bus.o_opCnt), 32'd8);

    // Backpressure holds the result and blocks grants
    doReset();
    applyStimulus(1'b0, 4'b0001, 8'b00_00_00_01, 64'h1234, 64'hFFFF, 1'b1);
    stepCycle("bpLoad");
    checkOutput("bp.load", 32'(bus.o_resOut), 32'h1234);
    applyStimulus(1'b0, 4'b0010, 8'h00, 64'h0000_0000_0000_1234, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepCycle("bpHold");
      checkOutput("bp.nogrant", 32'(lastGrant), 32'h0);
      checkOutput("bp.stable", 32'(bus.o_resOut), 32'h1234);
    end
    bus.i_resReady = 1'b1;
    stepCycle("bpRelease");
    checkOutput("bp.grant", 32'(lastGrant), 32'h2);
    checkOutput("bp.newout", 32'(bus.o_resOut), 32'hFFFF);

    // Reset while full with all requesters active
    applyStimulus(1'b1, 4'b1111, 8'h00, 64'h0, 64'h0, 1'b1);
    stepCycle("midRst");
    checkOutput("midrst.grant", 32'(lastGrant), 32'h0);
    checkOutput("midrst.valid", 32'(bus.o_resValid), 32'd0);
    checkOutput("midrst.cnt", 32'(bus.o_opCnt), 32'd0);
    rst = 1'b0;
    stepCycle("postRst");
    checkOutput("postrst.grant", 32'(lastGrant), 32'h1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rOp = 8'($urandom);
      rX = {$urandom, $urandom};
      rY = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 49) == 0), 4'($urandom), rOp, rX, rY, ($urandom_range(0, 9) < 7));
      stepCycle("rand");
    end

    // Counter wrap after 65536 accepts
    doReset();
    for (int i = 0; i < 65536; i++) begin
      rOp = 8'($urandom);
      rX = {$urandom, $urandom};
      rY = {$urandom, $urandom};
      applyStimulus(1'b0, 4'b1111, rOp, rX, rY, 1'b1);
      stepCycle("wrap");
    end
    checkOutput("wrap.cnt", 32'(bus.o_opCnt), 32'd0);
    checkOutput("wrap.id", 32'(bus.o_resId), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
